// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32 control path: ALU op codes,
// opcode/funct3 constants, operand-select encodings and the control state enum.
package core_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    // States that wait on the memory handshake and are guarded by the timeout.
    function automatic logic is_wait_state(input state_t st);
        return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the control FSM (master, ALU op producer) and the
// datapath/memory side (slave).
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        result_src;
    logic        pc_src;
    logic        pc_write;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal;
    logic        bus_err;

    modport master (
        input  instr, mem_ready, alu_zero,
        output alu_op, alu_src_a, alu_src_b, result_src, pc_src, pc_write,
               ir_write, mem_read, mem_write, reg_write, illegal, bus_err
    );

    modport slave (
        output instr, mem_ready, alu_zero,
        input  alu_op, alu_src_a, alu_src_b, result_src, pc_src, pc_write,
               ir_write, mem_read, mem_write, reg_write, illegal, bus_err
    );
endinterface

// File: rtl/alu_op_decode.sv
// funct3/funct7[5] to ALU op code decode, shared by the multi-cycle FSM and
// future pipelined control. funct7 is only meaningful for register-register ops.
module alu_op_decode
    import core_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       use_funct7_i,
    output logic [3:0] alu_op_o,
    output logic       valid_o
);

    logic alt_s;

    assign alt_s = use_funct7_i & funct7_5_i;

    // Map funct fields to an op code; unsupported combinations flag invalid.
    always_comb begin
        alu_op_o = ALU_ADD;
        valid_o  = 1'b0;
        case (funct3_i)
            F3_ADD: begin
                if (alt_s) begin
                    alu_op_o = ALU_SUB;
                end else begin
                    alu_op_o = ALU_ADD;
                end
                valid_o = 1'b1;
            end
            F3_AND: begin
                alu_op_o = ALU_AND;
                valid_o  = ~alt_s;
            end
            F3_OR: begin
                alu_op_o = ALU_OR;
                valid_o  = ~alt_s;
            end
            default: begin
                alu_op_o = ALU_ADD;
                valid_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32 core: fetch/decode/execute/memory/
// writeback sequencing with a timeout-guarded memory handshake.
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CW          = 5
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;

    logic [6:0]    opcode_s;
    logic [2:0]    funct3_s;
    logic [3:0]    dec_op_s;
    logic          dec_valid_s;
    logic          tmo_s;

    logic [3:0]    alu_op_s;
    logic [1:0]    src_a_s, src_b_s;
    logic          result_src_s, pc_src_s, pc_write_s, ir_write_s;
    logic          mem_read_s, mem_write_s, reg_write_s;
    logic          unused_instr_s;

    assign opcode_s       = bus.instr[6:0];
    assign funct3_s       = bus.instr[14:12];
    assign unused_instr_s = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    alu_op_decode u_alu_op_decode (
        .funct3_i     (funct3_s),
        .funct7_5_i   (bus.instr[30]),
        .use_funct7_i (state_q == S_EXEC_R),
        .alu_op_o     (dec_op_s),
        .valid_o      (dec_valid_s)
    );

    // The wait budget expires on the cycle the counter would reach MEM_TIMEOUT.
    assign tmo_s = is_wait_state(state_q) && !bus.mem_ready && (cnt_q == TMO_LAST);

    // State, timeout counter and sticky trap flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state and Moore control decode; reset forces the idle control word.
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        alu_op_s     = ALU_ADD;
        src_a_s      = SRC_A_PC;
        src_b_s      = SRC_B_RS2;
        result_src_s = 1'b0;
        pc_src_s     = 1'b0;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        if (rst) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read_s = 1'b1;
                    src_b_s    = SRC_B_FOUR;
                    if (bus.mem_ready) begin
                        ir_write_s = 1'b1;
                        pc_write_s = 1'b1;
                        state_d    = S_DECODE;
                    end else if (tmo_s) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_DECODE: begin
                    src_a_s = SRC_A_OLD_PC;
                    src_b_s = SRC_B_IMM;
                    case (opcode_s)
                        OP_R:               state_d = S_EXEC_R;
                        OP_I:               state_d = S_EXEC_I;
                        OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                        OP_BRANCH: begin
                            if (funct3_s == F3_BEQ) begin
                                state_d = S_BRANCH;
                            end else begin
                                state_d   = S_TRAP;
                                illegal_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: begin
                    src_a_s  = SRC_A_RS1;
                    src_b_s  = (state_q == S_EXEC_R) ? SRC_B_RS2 : SRC_B_IMM;
                    alu_op_s = dec_op_s;
                    if (dec_valid_s) begin
                        state_d = S_ALU_WB;
                    end else begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                end
                S_ALU_WB: begin
                    reg_write_s = 1'b1;
                    state_d     = S_FETCH;
                end
                S_MEM_ADDR: begin
                    src_a_s = SRC_A_RS1;
                    src_b_s = SRC_B_IMM;
                    if (opcode_s == OP_STORE) begin
                        state_d = S_MEM_WR;
                    end else begin
                        state_d = S_MEM_RD;
                    end
                end
                S_MEM_RD, S_MEM_WR: begin
                    mem_read_s  = (state_q == S_MEM_RD);
                    mem_write_s = (state_q == S_MEM_WR);
                    if (bus.mem_ready) begin
                        state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                    end else if (tmo_s) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_MEM_WB: begin
                    reg_write_s  = 1'b1;
                    result_src_s = 1'b1;
                    state_d      = S_FETCH;
                end
                S_BRANCH: begin
                    src_a_s    = SRC_A_RS1;
                    src_b_s    = SRC_B_RS2;
                    alu_op_s   = ALU_SUB;
                    pc_src_s   = 1'b1;
                    pc_write_s = bus.alu_zero;
                    state_d    = S_FETCH;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_TRAP;
                end
            endcase
        end
        // Counter restarts on every state entry and only runs while waiting.
        if (is_wait_state(state_q) && (state_d == state_q)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    assign bus.alu_op     = alu_op_s;
    assign bus.alu_src_a  = src_a_s;
    assign bus.alu_src_b  = src_b_s;
    assign bus.result_src = result_src_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.pc_write   = pc_write_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.illegal    = illegal_q;
    assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table for the normal
// instruction flows plus hand sequences for traps, timeout and reset.
module tb_multicycle_ctrl;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_ADDI = 32'hFFF08193;
    localparam logic [31:0] I_ANDI = 32'h0050F193;
    localparam logic [31:0] I_LW   = 32'h0080A283;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_XOR  = 32'h0020C1B3;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       result_src;
        logic       pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       illegal;
        logic       bus_err;
    } out_t;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic        rdy;
        logic        zero;
        out_t        exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(logic [3:0] op, logic [1:0] a, logic [1:0] b,
                                logic rs, logic ps, logic pw, logic iw,
                                logic mr, logic mw, logic rw);
        out_t o;
        o = '{alu_op: op, src_a: a, src_b: b, result_src: rs, pc_src: ps,
              pc_write: pw, ir_write: iw, mem_read: mr, mem_write: mw,
              reg_write: rw, illegal: 1'b0, bus_err: 1'b0};
        return o;
    endfunction

    // Expected control words per state, written straight from the state table.
    out_t e_fetch_rdy, e_fetch_wait, e_dec, e_aluwb, e_maddr, e_mrd, e_mwb, e_mwr;
    out_t e_idle, e_trap_ill, e_trap_berr;

    function automatic out_t e_exr(logic [3:0] op);
        return mk(op, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic out_t e_exi(logic [3:0] op);
        return mk(op, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic out_t e_br(logic z);
        return mk(A_SUB, 2'b01, 2'b00, 1'b0, 1'b1, z, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic out_t sample();
        out_t a;
        a.alu_op     = bus_if.alu_op;
        a.src_a      = bus_if.alu_src_a;
        a.src_b      = bus_if.alu_src_b;
        a.result_src = bus_if.result_src;
        a.pc_src     = bus_if.pc_src;
        a.pc_write   = bus_if.pc_write;
        a.ir_write   = bus_if.ir_write;
        a.mem_read   = bus_if.mem_read;
        a.mem_write  = bus_if.mem_write;
        a.reg_write  = bus_if.reg_write;
        a.illegal    = bus_if.illegal;
        a.bus_err    = bus_if.bus_err;
        return a;
    endfunction

    task automatic check(input string tag, input out_t exp);
        out_t act;
        act = sample();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (op,a,b,rs,ps,pw,iw,mr,mw,rw,ill,berr)",
                     tag, act, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, compare 1 ns later.
    task automatic step(input string tag, input logic [31:0] ins, input logic rdy,
                        input logic z, input out_t exp);
        @(negedge clk);
        rst              = 1'b0;
        bus_if.instr     = ins;
        bus_if.mem_ready = rdy;
        bus_if.alu_zero  = z;
        #1;
        check(tag, exp);
    endtask

    // Raise rst for one rising edge and check the idle control word while held.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst              = 1'b1;
        bus_if.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check(tag, e_idle);
    endtask

    task automatic add(input string tag, input logic [31:0] ins, input logic rdy,
                       input logic z, input out_t exp);
        vec_t v;
        v.tag = tag; v.instr = ins; v.rdy = rdy; v.zero = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic add_alu(input string tag, input logic [31:0] ins, input out_t ex);
        add({tag, "_fetch"}, ins, 1'b1, 1'b0, e_fetch_rdy);
        add({tag, "_decode"}, ins, 1'b1, 1'b0, e_dec);
        add({tag, "_exec"}, ins, 1'b1, 1'b0, ex);
        add({tag, "_wb"}, ins, 1'b1, 1'b0, e_aluwb);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst              = 1'b1;
        bus_if.instr     = 32'h0000_0013;
        bus_if.mem_ready = 1'b0;
        bus_if.alu_zero  = 1'b0;

        e_fetch_rdy  = mk(A_ADD, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        e_fetch_wait = mk(A_ADD, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e_dec        = mk(A_ADD, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_aluwb      = mk(A_ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e_maddr      = mk(A_ADD, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_mrd        = mk(A_ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e_mwb        = mk(A_ADD, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e_mwr        = mk(A_ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        e_idle       = mk(A_ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_trap_ill   = e_idle;
        e_trap_ill.illegal = 1'b1;
        e_trap_berr  = e_idle;
        e_trap_berr.bus_err = 1'b1;

        // Per-cycle table, starting in FETCH right after reset.
        add("fetch_wait0", I_ADD, 1'b0, 1'b0, e_fetch_wait);
        add("fetch_wait1", I_ADD, 1'b0, 1'b0, e_fetch_wait);
        add_alu("add", I_ADD, e_exr(A_ADD));
        add_alu("sub", I_SUB, e_exr(A_SUB));
        add_alu("and", I_AND, e_exr(A_AND));
        add_alu("or", I_OR, e_exr(A_OR));
        add_alu("addi_neg", I_ADDI, e_exi(A_ADD));
        add_alu("andi", I_ANDI, e_exi(A_AND));
        add("lw_fetch", I_LW, 1'b1, 1'b0, e_fetch_rdy);
        add("lw_decode", I_LW, 1'b1, 1'b0, e_dec);
        add("lw_addr", I_LW, 1'b1, 1'b0, e_maddr);
        add("lw_rd_w1", I_LW, 1'b0, 1'b0, e_mrd);
        add("lw_rd_w2", I_LW, 1'b0, 1'b0, e_mrd);
        add("lw_rd_w3", I_LW, 1'b0, 1'b0, e_mrd);
        add("lw_rd_done", I_LW, 1'b1, 1'b0, e_mrd);
        add("lw_wb", I_LW, 1'b1, 1'b0, e_mwb);
        add("sw_fetch", I_SW, 1'b1, 1'b0, e_fetch_rdy);
        add("sw_decode", I_SW, 1'b1, 1'b0, e_dec);
        add("sw_addr", I_SW, 1'b1, 1'b0, e_maddr);
        add("sw_wr_w1", I_SW, 1'b0, 1'b0, e_mwr);
        add("sw_wr_done", I_SW, 1'b1, 1'b0, e_mwr);
        add("beq_t_fetch", I_BEQ, 1'b1, 1'b1, e_fetch_rdy);
        add("beq_t_decode", I_BEQ, 1'b1, 1'b1, e_dec);
        add("beq_taken", I_BEQ, 1'b1, 1'b1, e_br(1'b1));
        add("beq_n_fetch", I_BEQ, 1'b1, 1'b0, e_fetch_rdy);
        add("beq_n_decode", I_BEQ, 1'b1, 1'b0, e_dec);
        add("beq_not_taken", I_BEQ, 1'b1, 1'b0, e_br(1'b0));
        add("after_beq_fetch", I_ADD, 1'b0, 1'b0, e_fetch_wait);

        do_reset("reset_initial");
        foreach (vecs[i]) begin
            step(vecs[i].tag, vecs[i].instr, vecs[i].rdy, vecs[i].zero, vecs[i].exp);
        end

        // Unsupported R-type funct3 traps from EXEC_R and stays trapped.
        do_reset("reset_before_xor");
        step("xor_fetch", I_XOR, 1'b1, 1'b0, e_fetch_rdy);
        step("xor_decode", I_XOR, 1'b1, 1'b0, e_dec);
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            step("xor_trap", I_XOR, c[0], 1'b1, e_trap_ill);
        end
        do_reset("reset_clears_illegal");
        step("after_xor_fetch", I_ADD, 1'b0, 1'b0, e_fetch_wait);

        // 16 cycles without ready in FETCH -> bus error trap.
        do_reset("reset_before_tmo");
        for (int c = 1; c <= 16; c++) begin
            step("tmo_fetch_wait", I_ADD, 1'b0, 1'b0, e_fetch_wait);
        end
        for (int c = 0; c < 3; c++) begin
            step("tmo_trapped", I_ADD, 1'b1, 1'b0, e_trap_berr);
        end
        do_reset("reset_clears_bus_err");

        // Ready on the 16th cycle still wins; then reset in the middle of MEM_WR.
        for (int c = 1; c <= 15; c++) begin
            step("late_fetch_wait", I_SW, 1'b0, 1'b0, e_fetch_wait);
        end
        step("late_fetch_rdy", I_SW, 1'b1, 1'b0, e_fetch_rdy);
        step("late_decode", I_SW, 1'b1, 1'b0, e_dec);
        step("late_addr", I_SW, 1'b1, 1'b0, e_maddr);
        step("late_wr_wait", I_SW, 1'b0, 1'b0, e_mwr);
        do_reset("reset_mid_mem_wr");
        step("after_wr_reset_fetch", I_SW, 1'b0, 1'b0, e_fetch_wait);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32 core. It is the producer side of the ALU operation-code interface. It sequences fetch, decode, execute, memory and writeback. Each cycle it drives the 4-bit ALU op code, operand selects and datapath write strobes. Memory accesses use a ready handshake guarded by a timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ready in any wait state before bus error (>=2)
CW, 5, width of timeout counter (2**CW > MEM_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
instr  in  32  instruction register contents (valid from DECODE onward)
mem_ready  in  1  memory handshake: access completes this cycle
alu_zero  in  1  ALU result == 0
alu_op  out  4  ALU op code: AND=0000, OR=0001, ADD=0010, SUB=0110
alu_src_a  out  2  00 PC, 01 rs1, 10 old PC
alu_src_b  out  2  00 rs2, 01 const 4, 10 immediate
result_src  out  1  0 ALU result register, 1 memory data
pc_src  out  1  0 ALU output (PC+4), 1 ALU result register (branch target)
pc_write  out  1  PC load strobe
ir_write  out  1  instruction register and old-PC load strobe
mem_read  out  1  memory read request (fetch or load)
mem_write  out  1  memory write request
reg_write  out  1  register file write strobe
illegal  out  1  sticky: unsupported instruction trapped
bus_err  out  1  sticky: memory timeout trapped

Behaviour:
- Reset (rst high at clk edge): state=FETCH, timeout counter=0, illegal=0, bus_err=0. All strobes=0, alu_op=ADD, selects=00. Reset overrides any state, including a pending memory wait.
- Control outputs are Moore decodes of state, except these fetch/branch strobes:
  - ir_write, pc_write in FETCH: asserted only in the cycle mem_ready=1.
  - pc_write in BRANCH: asserted only when alu_zero=1.
- FETCH: mem_read=1, src_a=00, src_b=01, ADD. mem_ready=1 -> DECODE.
- DECODE: src_a=10, src_b=10, ADD (branch target into ALU result register). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011, 0100011 -> MEM_ADDR
  - 1100011 with funct3=000 -> BRANCH
  - else -> TRAP with illegal=1
- EXEC_R: src_a=01, src_b=00. Op code from funct3/funct7[5]:
  - 000/0 ADD; 000/1 SUB; 111/0 AND; 110/0 OR
  - other combinations -> TRAP, illegal=1
  - valid -> ALU_WB
- EXEC_I: src_a=01, src_b=10. funct3 000 ADD, 111 AND, 110 OR; else TRAP. Valid -> ALU_WB.
- ALU_WB: reg_write=1, result_src=0 -> FETCH.
- MEM_ADDR: src_a=01, src_b=10, ADD. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_read=1; mem_ready -> MEM_WB. MEM_WB: reg_write=1, result_src=1 -> FETCH.
- MEM_WR: mem_write=1; mem_ready -> FETCH.
- BRANCH: src_a=01, src_b=00, SUB, pc_src=1; pc_write=alu_zero -> FETCH.
- Timeout in FETCH, MEM_RD, MEM_WR:
  - Counter clears on entry and increments each cycle mem_ready=0.
  - Counter reaching MEM_TIMEOUT with mem_ready still 0 -> TRAP, bus_err=1.
  - mem_ready=1 on the same cycle wins; the access completes normally.
- TRAP: all strobes 0; exit only by reset.
- Latency with mem_ready=1 on first cycle: R/I-type 4 cycles, load 5, store 4, branch 3.

Decomposition:
- Shared package core_pkg: ALU op codes (AND/OR/ADD/SUB), opcode constants, src_a/src_b select encodings, state enum.
- Op-code decode (funct3/funct7 -> alu_op, valid) goes in one combinational sub-module, alu_op_decode. The FSM and a future pipelined control reuse it.

Test Plan:
- instr=0x002081B3 (add x3,x1,x2), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALU_WB; alu_op=0010 in EXEC_R; reg_write=1 exactly one cycle; back in FETCH at cycle 4.
- instr=0x402081B3 (sub) -> alu_op=0110 in EXEC_R. Same flow with funct3=111 and 110 -> alu_op=0000 and 0001 respectively.
- instr=0x0080A283 (lw x5,8(x1)), mem_ready held low 3 cycles in MEM_RD -> mem_read stays 1 for 4 cycles; then MEM_WB with result_src=1, reg_write=1.
- instr=0x00208463 (beq) with alu_zero=1 -> BRANCH: alu_op=0110, pc_src=1, pc_write=1. With alu_zero=0 -> pc_write=0; both cases return to FETCH.
- instr=0x0020C1B3 (xor, unsupported) -> TRAP, illegal=1, strobes 0 for 20 cycles; rst pulse -> FETCH, illegal=0.
- mem_ready=0 in FETCH -> bus_err=1 after MEM_TIMEOUT=16 cycles. Separately, mem_ready=1 on cycle 16 -> normal DECODE, bus_err=0. rst asserted mid-MEM_WR -> FETCH next cycle, mem_write=0.
